// File: rtl/multi_ch_pulse_req_gen.sv
// ---------------------------------------------------------------------------
// multi_ch_pulse_req_gen
//
// Source-domain half of a pulse handshake transfer. Each channel turns
// single-cycle pulses on pulse_in into four-phase request/acknowledge
// handshakes. Pulses that arrive while a handshake is in flight are queued
// in a saturating per-channel counter and replayed one handshake each.
//
// Ports:
//   src_clock    source clock, all logic on its rising edge
//   src_reset    asynchronous active-low reset
//   pulse_in     per-channel single-cycle pulse
//   ack_async    per-channel acknowledge level from the destination domain
//   clear_ovf    per-channel synchronous clear of the overflow flag
//   request      per-channel registered request level
//   pending_cnt  per-channel queued pulse count, channel i at [i*CNT_W +: CNT_W]
//   overflow     per-channel sticky flag: a pulse was lost to saturation
//   busy         any channel mid-handshake or holding queued pulses
// ---------------------------------------------------------------------------
module multi_ch_pulse_req_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    src_clock,
  input  logic                    src_reset,
  input  logic [NUM_CH-1:0]       pulse_in,
  input  logic [NUM_CH-1:0]       ack_async,
  input  logic [NUM_CH-1:0]       clear_ovf,
  output logic [NUM_CH-1:0]       request,
  output logic [NUM_CH*CNT_W-1:0] pending_cnt,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_ACK_LOW = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] ch_busy;

  assign busy = |ch_busy;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      logic                   ack_sync;
      state_t                 state_reg, state_next;
      logic [CNT_W-1:0]       cnt_reg, cnt_next;
      logic                   ovf_reg, ovf_next;
      logic                   req_reg, req_next;
      logic                   inc, dec, ovf_set;

      // Plain flop chain; only the last stage feeds the FSM.
      always_ff @(posedge src_clock or negedge src_reset) begin
        if (!src_reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_async[gi]};
        end
      end

      assign ack_sync = sync_reg[SYNC_STAGES-1];

      always_ff @(posedge src_clock or negedge src_reset) begin
        if (!src_reset) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
          ovf_reg   <= 1'b0;
          req_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          ovf_reg   <= ovf_next;
          req_reg   <= req_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        inc        = 1'b0;
        dec        = 1'b0;
        ovf_set    = 1'b0;

        unique case (state_reg)
          ST_IDLE: begin
            // A pulse in IDLE is consumed by the handshake it starts.
            // A stale ack_sync here is deliberately ignored.
            if (pulse_in[gi]) state_next = ST_REQ;
          end
          ST_REQ: begin
            inc = pulse_in[gi];
            if (ack_sync) state_next = ST_ACK_LOW;
          end
          ST_ACK_LOW: begin
            if (!ack_sync) begin
              if (cnt_reg != '0) begin
                // Replay one queued pulse; a coincident pulse re-queues.
                dec        = 1'b1;
                inc        = pulse_in[gi];
                state_next = ST_REQ;
              end else begin
                // Nothing queued: a coincident pulse starts the next
                // handshake directly, exactly as it would from IDLE.
                state_next = pulse_in[gi] ? ST_REQ : ST_IDLE;
              end
            end else begin
              inc = pulse_in[gi];
            end
          end
          default: state_next = ST_IDLE;
        endcase

        // Increment and decrement on the same edge cancel, so saturation
        // only loses a pulse when no replay frees a slot.
        if (inc && !dec) begin
          if (cnt_reg == CNT_MAX) ovf_set = 1'b1;
          else                    cnt_next = cnt_reg + 1'b1;
        end else if (dec && !inc) begin
          cnt_next = cnt_reg - 1'b1;
        end

        if (ovf_set)            ovf_next = 1'b1;
        else if (clear_ovf[gi]) ovf_next = 1'b0;
      end

      // Request is registered from the next state so it leaves the block
      // straight off a flop.
      assign req_next = (state_next == ST_REQ);

      assign request[gi]                      = req_reg;
      assign pending_cnt[gi*CNT_W +: CNT_W]   = cnt_reg;
      assign overflow[gi]                     = ovf_reg;
      assign ch_busy[gi]                      = (state_reg != ST_IDLE) || (cnt_reg != '0);
    end
  endgenerate

endmodule

// File: tb/tb_multi_ch_pulse_req_gen.sv
// ---------------------------------------------------------------------------
// tb_multi_ch_pulse_req_gen
//
// Directed bench for multi_ch_pulse_req_gen with a per-channel destination
// model that echoes request back on ack_async after a programmable delay.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multi_ch_pulse_req_gen;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;

  logic                    src_clock;
  logic                    src_reset;
  logic [NUM_CH-1:0]       pulse_in;
  logic [NUM_CH-1:0]       ack_async = '0;
  logic [NUM_CH-1:0]       clear_ovf;
  logic [NUM_CH-1:0]       request;
  logic [NUM_CH*CNT_W-1:0] pending_cnt;
  logic [NUM_CH-1:0]       overflow;
  logic                    busy;

  int n_checks = 0;
  int n_fail   = 0;

  // destination model state
  logic [7:0] hist [NUM_CH];
  int         dly  [NUM_CH];

  // request monitor
  logic       prev_req [NUM_CH];
  int         rises    [NUM_CH];
  int         low_run  [NUM_CH];
  int         min_low  [NUM_CH];

  multi_ch_pulse_req_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .src_clock   (src_clock),
    .src_reset   (src_reset),
    .pulse_in    (pulse_in),
    .ack_async   (ack_async),
    .clear_ovf   (clear_ovf),
    .request     (request),
    .pending_cnt (pending_cnt),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial begin
    src_clock = 1'b0;
    forever #5 src_clock = ~src_clock;
  end

  // Destination: ack follows request dly[i] falling edges later.
  always @(negedge src_clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!src_reset) hist[i] = '0;
      else            hist[i] = {hist[i][6:0], request[i]};
      ack_async[i] = hist[i][dly[i]];
    end
  end

  always @(negedge src_clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (request[i] && !prev_req[i]) begin
        if (rises[i] > 0 && low_run[i] < min_low[i]) min_low[i] = low_run[i];
        rises[i] = rises[i] + 1;
      end
      low_run[i]  = request[i] ? 0 : low_run[i] + 1;
      prev_req[i] = request[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return pending_cnt[ch*CNT_W +: CNT_W];
  endfunction

  // Hold pulse_in[ch] high for n cycles; returns on the n-th falling edge
  // with the pulse already removed.
  task automatic pulse_burst(input int ch, input int n);
    pulse_in[ch] = 1'b1;
    repeat (n) @(negedge src_clock);
    pulse_in[ch] = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (!busy) break;
      @(negedge src_clock);
    end
    chk(tag, busy, 1'b0);
    repeat (3) @(negedge src_clock);
  endtask

  // Cleared while the clock is high so it never races the monitor.
  task automatic mon_clear();
    @(posedge src_clock);
    for (int i = 0; i < NUM_CH; i++) begin
      rises[i]   = 0;
      low_run[i] = 0;
      min_low[i] = 255;
    end
    @(negedge src_clock);
  endtask

  initial begin
    src_reset = 1'b0;
    pulse_in  = '0;
    clear_ovf = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hist[i] = '0; dly[i] = 3; prev_req[i] = 1'b0;
      rises[i] = 0; low_run[i] = 0; min_low[i] = 255;
    end

    // reset state
    repeat (3) @(negedge src_clock);
    chk("rst_request",  request,     '0);
    chk("rst_pending",  pending_cnt, '0);
    chk("rst_overflow", overflow,    '0);
    chk("rst_busy",     busy,        1'b0);
    src_reset = 1'b1;
    repeat (2) @(negedge src_clock);
    mon_clear();

    // single pulse on ch0, ack delay 3
    pulse_burst(0, 1);
    chk("t1_req_rise", request[0], 1'b1);
    chk("t1_cnt0",     cnt_of(0),  4'd0);
    chk("t1_busy",     busy,       1'b1);
    repeat (5) @(negedge src_clock);
    chk("t1_req_hold", request[0], 1'b1);
    @(negedge src_clock);
    chk("t1_req_fall", request[0], 1'b0);
    repeat (5) @(negedge src_clock);
    chk("t1_busy_acklow", busy, 1'b1);
    @(negedge src_clock);
    chk("t1_busy_idle", busy, 1'b0);
    chk("t1_rises", rises[0], 1);
    mon_clear();

    // five back-to-back pulses on ch1
    pulse_burst(1, 5);
    chk("t2_cnt4", cnt_of(1), 4'd4);
    repeat (8) @(negedge src_clock);
    chk("t2_cnt3_after_first", cnt_of(1), 4'd3);
    chk("t2_replay_req", request[1], 1'b1);
    wait_idle("t2_idle", 200);
    chk("t2_rises",   rises[1],  5);
    chk("t2_min_low", min_low[1], 6);
    chk("t2_cnt_end", cnt_of(1), 4'd0);
    mon_clear();

    // saturation on ch2 with a long handshake
    dly[2] = 7;
    pulse_burst(2, 17);
    chk("t3_cnt_sat", cnt_of(2),    4'd15);
    chk("t3_ovf",     overflow,     4'b0100);
    wait_idle("t3_idle", 1000);
    chk("t3_rises",      rises[2],    16);
    chk("t3_ovf_sticky", overflow[2], 1'b1);
    clear_ovf[2] = 1'b1;
    @(negedge src_clock);
    clear_ovf[2] = 1'b0;
    chk("t3_ovf_clr", overflow[2], 1'b0);
    dly[2] = 3;
    mon_clear();

    // pulse coincident with completion, pending 3
    pulse_burst(3, 4);
    chk("t4a_cnt3", cnt_of(3), 4'd3);
    repeat (8) @(negedge src_clock);
    pulse_burst(3, 1);
    chk("t4a_cnt_keep", cnt_of(3),  4'd3);
    chk("t4a_req",      request[3], 1'b1);
    wait_idle("t4a_idle", 300);
    chk("t4a_rises", rises[3], 5);
    mon_clear();

    // pulse coincident with completion, pending 0
    pulse_burst(3, 1);
    repeat (11) @(negedge src_clock);
    pulse_burst(3, 1);
    chk("t4b_cnt0", cnt_of(3),  4'd0);
    chk("t4b_req",  request[3], 1'b1);
    wait_idle("t4b_idle", 200);
    chk("t4b_rises", rises[3], 2);
    mon_clear();

    // all channels, staggered pulses, different ack delays
    for (int i = 0; i < NUM_CH; i++) dly[i] = i + 1;
    pulse_in[0] = 1'b1;
    @(negedge src_clock);
    pulse_in = 4'b0010;
    chk("t5_req_a", request, 4'b0001);
    @(negedge src_clock);
    pulse_in = 4'b0100;
    chk("t5_req_b", request, 4'b0011);
    @(negedge src_clock);
    pulse_in = 4'b1000;
    chk("t5_req_c", request, 4'b0111);
    @(negedge src_clock);
    pulse_in = '0;
    chk("t5_req_d", request,     4'b1111);
    chk("t5_cnt",   pending_cnt, '0);
    wait_idle("t5_idle", 200);
    for (int i = 0; i < NUM_CH; i++) chk($sformatf("t5_rises_ch%0d", i), rises[i], 1);
    mon_clear();

    // asynchronous reset mid-REQ with six queued pulses on ch0
    for (int i = 0; i < NUM_CH; i++) dly[i] = 3;
    dly[0] = 7;
    pulse_burst(0, 7);
    chk("t6_cnt6",   cnt_of(0),  4'd6);
    chk("t6_in_req", request[0], 1'b1);
    #2;
    src_reset = 1'b0;
    #1;
    chk("t6_rst_req",  request,     '0);
    chk("t6_rst_cnt",  pending_cnt, '0);
    chk("t6_rst_ovf",  overflow,    '0);
    chk("t6_rst_busy", busy,        1'b0);
    repeat (2) @(negedge src_clock);
    src_reset = 1'b1;
    dly[0] = 3;
    @(negedge src_clock);
    pulse_burst(0, 1);
    chk("t6_fresh_req", request[0], 1'b1);
    chk("t6_fresh_cnt", cnt_of(0),  4'd0);
    wait_idle("t6_idle", 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
